// File: rtl/j1_wb_lsu_if.sv
// Wishbone master bus bundle between the J1 load/store unit and the shared arbiter.
interface j1_wb_lsu_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 32
);
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_we_o;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic [DW/8-1:0] wb_sel_o;
  logic [DW-1:0] wb_dat_i;
  logic          wb_ack_i;
  logic          wb_err_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/j1_wb_lsu.sv
// J1 load/store unit: one CPU access at a time, either as a registered Wishbone
// cycle (wait states, bus error, timeout) or as a single-cycle UART window strobe.
module j1_wb_lsu #(
  parameter int unsigned         DW       = 32,
  parameter int unsigned         AW       = 32,
  parameter int unsigned         IO_TAG_W = 4,
  parameter logic [IO_TAG_W-1:0] IO_TAG   = 4'hF,
  parameter int unsigned         TIMEOUT  = 255,
  parameter int unsigned         ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_i,
  input  logic                req_we_i,
  input  logic [AW-1:0]       req_adr_i,
  input  logic [DW-1:0]       req_dat_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [DW-1:0]       rdata_o,
  output logic                err_o,
  output logic [ERRCNT_W-1:0] err_cnt_o,
  j1_wb_lsu_if.master         wb,
  output logic                io_rd_o,
  output logic                io_wr_o,
  output logic                io_adr_o,
  output logic [7:0]          io_dat_o,
  input  logic [7:0]          io_dat_i
);

  localparam int unsigned   CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned   TLAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] TLAST   = CW'(TLAST_I);

  typedef enum logic [1:0] {S_IDLE, S_WB, S_IO, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       adr_q, adr_d;
  logic [DW-1:0]       dat_q, dat_d;
  logic                we_q, we_d;
  logic [CW-1:0]       wcnt_q, wcnt_d;
  logic                cyc_q, cyc_d;
  logic                io_rd_q, io_rd_d;
  logic                io_wr_q, io_wr_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [DW-1:0]       rdata_q, rdata_d;
  logic [ERRCNT_W-1:0] errcnt_q, errcnt_d;
  logic                fail;

  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    we_d     = we_q;
    wcnt_d   = wcnt_q;
    cyc_d    = 1'b0;
    io_rd_d  = 1'b0;
    io_wr_d  = 1'b0;
    done_d   = 1'b0;
    err_d    = err_q;
    rdata_d  = rdata_q;
    errcnt_d = errcnt_q;
    fail     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          adr_d = req_adr_i;
          dat_d = req_dat_i;
          we_d  = req_we_i;
          if (req_adr_i[AW-1 -: IO_TAG_W] == IO_TAG) begin
            state_d = S_IO;
            io_rd_d = !req_we_i;
            io_wr_d = req_we_i;
          end else begin
            state_d = S_WB;
            cyc_d   = 1'b1;
            wcnt_d  = '0;
          end
        end
      end
      S_WB: begin
        // Error beats ack; timeout only fires on a cycle with neither.
        fail = wb.wb_err_i ||
               ((TIMEOUT != 0) && !wb.wb_ack_i && (wcnt_q == TLAST));
        if (fail) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
          if (errcnt_q != '1) errcnt_d = errcnt_q + 1'b1;
        end else if (wb.wb_ack_i) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          err_d   = 1'b0;
          if (!we_q) rdata_d = wb.wb_dat_i;
        end else begin
          cyc_d  = 1'b1;
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_IO: begin
        state_d = S_DONE;
        done_d  = 1'b1;
        err_d   = 1'b0;
        if (!we_q) rdata_d = {{(DW-8){1'b0}}, io_dat_i};
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      adr_q    <= '0;
      dat_q    <= '0;
      we_q     <= 1'b0;
      wcnt_q   <= '0;
      cyc_q    <= 1'b0;
      io_rd_q  <= 1'b0;
      io_wr_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      errcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      we_q     <= we_d;
      wcnt_q   <= wcnt_d;
      cyc_q    <= cyc_d;
      io_rd_q  <= io_rd_d;
      io_wr_q  <= io_wr_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;
  assign err_cnt_o   = errcnt_q;
  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = cyc_q;
  assign wb.wb_we_o  = we_q & cyc_q;
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_sel_o = {(DW/8){cyc_q}};
  assign io_rd_o     = io_rd_q;
  assign io_wr_o     = io_wr_q;
  assign io_adr_o    = adr_q[0];
  assign io_dat_o    = dat_q[7:0];

endmodule

// File: tb/tb_j1_wb_lsu.sv
// Self-checking bench for j1_wb_lsu: per-access schedule model plus randomized traffic.
module tb_j1_wb_lsu;
  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 32;
  localparam int unsigned TMO = 4;
  localparam int unsigned ECW = 8;
  localparam int unsigned ECMAX = (1 << ECW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          req_i, req_we_i;
  logic [AW-1:0] req_adr_i;
  logic [DW-1:0] req_dat_i;
  logic          busy_o, done_o, err_o;
  logic [DW-1:0] rdata_o;
  logic [ECW-1:0] err_cnt_o;
  logic          io_rd_o, io_wr_o, io_adr_o;
  logic [7:0]    io_dat_o, io_dat_i;

  j1_wb_lsu_if #(.DW(DW), .AW(AW)) wb ();

  j1_wb_lsu #(
    .DW(DW), .AW(AW), .IO_TAG_W(4), .IO_TAG(4'hF), .TIMEOUT(TMO), .ERRCNT_W(ECW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_i(req_i), .req_we_i(req_we_i), .req_adr_i(req_adr_i), .req_dat_i(req_dat_i),
    .busy_o(busy_o), .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o), .err_cnt_o(err_cnt_o),
    .wb(wb.master),
    .io_rd_o(io_rd_o), .io_wr_o(io_wr_o), .io_adr_o(io_adr_o), .io_dat_o(io_dat_o),
    .io_dat_i(io_dat_i)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected per-cycle view, written by the driver, read by the compare process
  logic          chk_on = 1'b0;
  logic          e_busy, e_done, e_cyc, e_we, e_iord, e_iowr, e_ioadr, e_err;
  logic [AW-1:0] e_adr;
  logic [DW-1:0] e_dat;
  logic [7:0]    e_iodat;
  logic [DW-1:0] m_rdata = '0;
  int unsigned   m_errcnt = 0;
  int            cyc_no = 0;
  int            req_cyc = -1;
  int            done_lat = 0, cyc_hi = 0, iord_cnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("busy", busy_o, e_busy);
        chk("done", done_o, e_done);
        chk("wb_cyc", wb.wb_cyc_o, e_cyc);
        chk("wb_stb", wb.wb_stb_o, e_cyc);
        chk("io_rd", io_rd_o, e_iord);
        chk("io_wr", io_wr_o, e_iowr);
        chk("rdata", rdata_o, m_rdata);
        chk("err_cnt", err_cnt_o, 64'(m_errcnt));
        if (e_cyc) begin
          chk("wb_we", wb.wb_we_o, e_we);
          chk("wb_adr", wb.wb_adr_o, e_adr);
          chk("wb_dat", wb.wb_dat_o, e_dat);
          chk("wb_sel", wb.wb_sel_o, 4'hF);
        end
        if (e_iord || e_iowr) begin
          chk("io_adr", io_adr_o, e_ioadr);
          chk("io_dat", io_dat_o, e_iodat);
        end
        if (e_done) chk("err", err_o, e_err);
        if (cyc_no == req_cyc) begin
          cyc_hi   = 0;
          iord_cnt = 0;
        end else begin
          if (wb.wb_cyc_o) cyc_hi++;
          if (io_rd_o) iord_cnt++;
        end
        if (done_o) done_lat = cyc_no - req_cyc;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #2;
    cyc_no++;
  endtask

  task automatic idle_exp();
    e_busy = 1'b0; e_done = 1'b0; e_cyc = 1'b0; e_iord = 1'b0; e_iowr = 1'b0;
  endtask

  // Inputs the DUT must ignore in the current cycle
  task automatic noise();
    req_i          = 1'($urandom);
    req_we_i       = 1'($urandom);
    req_adr_i      = $urandom;
    req_dat_i      = $urandom;
    wb.wb_ack_i    = ($urandom % 3 == 0);
    wb.wb_err_i    = ($urandom % 6 == 0);
    wb.wb_dat_i    = $urandom;
    io_dat_i       = 8'($urandom);
  endtask

  task automatic idle_cycle();
    next_cycle();
    idle_exp();
    noise();
    req_i = 1'b0;
  endtask

  // kind: 0 ack, 1 err, 2 ack+err, 3 silent; waits = stb cycles before the response
  task automatic run_access(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                            input int kind, input int waits, input logic [DW-1:0] rsp,
                            input logic [7:0] iod);
    int cycles;
    logic resp, x_err;
    logic [DW-1:0] rd;
    next_cycle();
    idle_exp();
    noise();
    req_i = 1'b1; req_we_i = we; req_adr_i = adr; req_dat_i = dat;
    req_cyc = cyc_no;
    if (adr[AW-1 -: 4] == 4'hF) begin
      next_cycle();
      noise();
      e_busy = 1'b1; e_iord = !we; e_iowr = we;
      e_ioadr = adr[0]; e_iodat = dat[7:0];
      io_dat_i = iod;
      x_err = 1'b0;
      rd = we ? m_rdata : {24'h0, iod};
    end else begin
      resp   = (kind != 3) && (waits < int'(TMO));
      cycles = resp ? waits + 1 : int'(TMO);
      x_err  = !resp || (kind != 0);
      rd     = x_err ? '0 : (we ? m_rdata : rsp);
      for (int k = 1; k <= cycles; k++) begin
        next_cycle();
        noise();
        e_busy = 1'b1; e_cyc = 1'b1; e_we = we; e_adr = adr; e_dat = dat;
        wb.wb_ack_i = resp && (k == cycles) && (kind == 0 || kind == 2);
        wb.wb_err_i = resp && (k == cycles) && (kind == 1 || kind == 2);
        if (resp && k == cycles) wb.wb_dat_i = rsp;
      end
    end
    next_cycle();
    noise();
    e_busy = 1'b1; e_cyc = 1'b0; e_iord = 1'b0; e_iowr = 1'b0;
    e_done = 1'b1; e_err = x_err;
    m_rdata = rd;
    if (x_err && m_errcnt < ECMAX) m_errcnt++;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got no completion want finish by 1ms");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] a;
    int r, kind;
    rst = 1'b0;
    req_i = 1'b0; req_we_i = 1'b0; req_adr_i = '0; req_dat_i = '0;
    wb.wb_ack_i = 1'b0; wb.wb_err_i = 1'b0; wb.wb_dat_i = '0; io_dat_i = '0;
    #12;
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_cyc", wb.wb_cyc_o, 0);
    chk("rst_stb", wb.wb_stb_o, 0);
    chk("rst_sel", wb.wb_sel_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_errcnt", err_cnt_o, 0);
    chk("rst_io", {io_rd_o, io_wr_o, io_adr_o}, 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    idle_exp();
    chk_on = 1'b1;
    idle_cycle();

    run_access(1'b0, 32'h0000_0100, 32'h0, 0, 0, 32'hDEAD_BEEF, 8'h0);
    @(negedge clk); #1;
    chk("d_load_lat", done_lat, 2);
    chk("d_load_rdata", rdata_o, 32'hDEAD_BEEF);
    chk("d_load_err", err_o, 0);

    run_access(1'b1, 32'h0000_0200, 32'h1234_5678, 0, 3, 32'h0BAD_0BAD, 8'h0);
    @(negedge clk); #1;
    chk("d_store_lat", done_lat, 5);
    chk("d_store_cyc", cyc_hi, 4);
    chk("d_store_rdata", rdata_o, 32'hDEAD_BEEF);

    run_access(1'b0, 32'hF000_0001, 32'h0, 0, 0, 32'h0, 8'h41);
    @(negedge clk); #1;
    chk("d_uart_lat", done_lat, 2);
    chk("d_uart_rdata", rdata_o, 32'h0000_0041);
    chk("d_uart_nocyc", cyc_hi, 0);
    chk("d_uart_rd", iord_cnt, 1);

    run_access(1'b0, 32'h0000_0400, 32'h0, 3, 0, 32'h0, 8'h0);
    @(negedge clk); #1;
    chk("d_tmo_cyc", cyc_hi, 4);
    chk("d_tmo_lat", done_lat, 5);
    chk("d_tmo_err", err_o, 1);
    chk("d_tmo_cnt", err_cnt_o, 1);

    run_access(1'b0, 32'h0000_0500, 32'h0, 2, 1, 32'hCAFE_F00D, 8'h0);
    @(negedge clk); #1;
    chk("d_both_err", err_o, 1);
    chk("d_both_cnt", err_cnt_o, 2);
    chk("d_both_rdata", rdata_o, 0);

    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 2);
      for (int g = 0; g < r; g++) idle_cycle();
      if ($urandom % 4 == 0) a = {4'hF, 28'($urandom)};
      else a = {4'($urandom_range(0, 14)), 28'($urandom)};
      r = $urandom % 20;
      kind = (r < 12) ? 0 : (r < 15) ? 1 : (r < 17) ? 2 : 3;
      run_access(1'($urandom), a, $urandom, kind, $urandom_range(0, 5), $urandom, 8'($urandom));
    end

    for (int n = 0; n < 256; n++)
      run_access(1'($urandom), {4'h1, 28'($urandom)}, $urandom, 1, 0, $urandom, 8'h0);
    @(negedge clk); #1;
    chk("d_sat_cnt", err_cnt_o, 8'hFF);

    next_cycle();
    idle_exp();
    noise();
    req_i = 1'b1; req_we_i = 1'b0; req_adr_i = 32'h0000_0300; req_dat_i = 32'h55AA_55AA;
    req_cyc = cyc_no;
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      noise();
      req_i = 1'b0; wb.wb_ack_i = 1'b0; wb.wb_err_i = 1'b0;
      e_busy = 1'b1; e_cyc = 1'b1; e_we = 1'b0; e_adr = 32'h0000_0300; e_dat = 32'h55AA_55AA;
    end
    next_cycle();
    chk_on = 1'b0;
    req_i = 1'b0; wb.wb_ack_i = 1'b0; wb.wb_err_i = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    chk("d_rst_cyc", wb.wb_cyc_o, 0);
    chk("d_rst_busy", busy_o, 0);
    chk("d_rst_done", done_o, 0);
    chk("d_rst_cnt", err_cnt_o, 0);
    chk("d_rst_rdata", rdata_o, 0);
    m_rdata = '0;
    m_errcnt = 0;
    next_cycle();
    chk("d_rst_hold_done", done_o, 0);
    next_cycle();
    rst = 1'b1;
    idle_exp();
    chk_on = 1'b1;
    for (int k = 0; k < 4; k++) idle_cycle();
    run_access(1'b0, 32'h0000_0600, 32'h0, 0, 1, 32'h0123_4567, 8'h0);
    idle_cycle();

    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
